// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide two's-complement add/subtract done one nibble per clock on a shared 4-bit slice.
// The result, carry/borrow and overflow are published together when the last nibble completes.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   c,
    output logic                   v
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   work;
    logic [W-1:0]   work_next;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           sub_q;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [4:0]     nib_sum;
    logic           nib_cy;
    logic           nib_c3;
    logic           last;

    // Handshake: start is taken only on an edge where ready=1; while busy it is dropped, not queued.
    assign ready = (state == S_IDLE);
    assign busy  = ~ready;
    assign done  = (state == S_DONE);

    always_comb begin
        nib_a     = op_a[4*idx +: 4];
        nib_b     = op_b[4*idx +: 4];
        nib_sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        nib_cy    = nib_sum[4];
        // Carry into bit 3 recovered from the sum bit, used for overflow on the top nibble.
        nib_c3    = nib_a[3] ^ nib_b[3] ^ nib_sum[3];
        work_next = work;
        work_next[4*idx +: 4] = nib_sum[3:0];
        last      = (idx == IW'(NIBBLES - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last)  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            work   <= '0;
            result <= '0;
            c      <= 1'b0;
            v      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        sub_q <= sub;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    work  <= work_next;
                    carry <= nib_cy;
                    if (last) begin
                        idx    <= '0;
                        result <= work_next;
                        c      <= sub_q ^ nib_cy;
                        v      <= nib_c3 ^ nib_cy;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl: a 4-nibble and a 1-nibble instance checked
// against an arithmetic model every cycle, plus hand-computed expectations per operation.
module tb_nibble_serial_addsub_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start4, sub4, ready4, busy4, done4, c4, v4;
    logic [15:0] a4, b4, result4;
    logic        start1, sub1, ready1, busy1, done1, c1, v1;
    logic [3:0]  a1, b1, result1;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .result(result4), .c(c4), .v(v4)
    );

    nibble_serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .result(result1), .c(c1), .v(v1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- arithmetic model ----------------
    function automatic void calc(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 input int w, output logic [15:0] r, output logic co,
                                 output logic vo);
        int unsigned m;
        int unsigned aa;
        int unsigned bb;
        int unsigned full;
        logic sa, sb, sr;
        m  = (32'd1 << w) - 1;
        aa = 32'(a) & m;
        bb = 32'(b) & m;
        if (!s) begin
            full = aa + bb;
            co   = ((full >> w) & 1) != 0;
        end else begin
            full = aa - bb;
            co   = (aa < bb);
        end
        r  = 16'(full & m);
        sa = ((aa >> (w - 1)) & 1) != 0;
        sb = ((bb >> (w - 1)) & 1) != 0;
        sr = ((32'(r) >> (w - 1)) & 1) != 0;
        vo = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    // Model: phase 0 = idle, 1..n = computing nibbles, n+1 = done cycle.
    int          ph [2];
    logic [15:0] e_res [2];
    logic        e_c [2];
    logic        e_v [2];
    logic [15:0] p_res [2];
    logic        p_c [2];
    logic        p_v [2];
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    int          m_n;
    logic        m_st, m_sub;
    logic [15:0] m_a, m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                ph[d]    = 0;
                e_res[d] = '0;
                e_c[d]   = 1'b0;
                e_v[d]   = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_n   = (d == 0) ? 4 : 1;
                m_st  = (d == 0) ? start4 : start1;
                m_sub = (d == 0) ? sub4 : sub1;
                m_a   = (d == 0) ? a4 : {12'h000, a1};
                m_b   = (d == 0) ? b4 : {12'h000, b1};
                if (ph[d] == 0) begin
                    if (m_st) begin
                        calc(m_a, m_b, m_sub, 4 * m_n, p_res[d], p_c[d], p_v[d]);
                        if (d == 0) exp_q0.push_back(p_res[d]);
                        else        exp_q1.push_back(p_res[d]);
                        ph[d] = 1;
                    end
                end else if (ph[d] <= m_n) begin
                    ph[d] = ph[d] + 1;
                    if (ph[d] == m_n + 1) begin
                        e_res[d] = p_res[d];
                        e_c[d]   = p_c[d];
                        e_v[d]   = p_v[d];
                    end
                end else begin
                    ph[d] = 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    task automatic cmp_dut(input int d);
        int          n;
        logic [15:0] exp;
        string       tag;
        n   = (d == 0) ? 4 : 1;
        tag = (d == 0) ? "n4" : "n1";
        check({tag, " ready"}, 16'((d == 0) ? ready4 : ready1), 16'(ph[d] == 0));
        check({tag, " busy"},  16'((d == 0) ? busy4 : busy1),   16'(ph[d] != 0));
        check({tag, " done"},  16'((d == 0) ? done4 : done1),   16'(ph[d] == n + 1));
        check({tag, " result"}, (d == 0) ? result4 : {12'h000, result1}, e_res[d]);
        check({tag, " c"}, 16'((d == 0) ? c4 : c1), 16'(e_c[d]));
        check({tag, " v"}, 16'((d == 0) ? v4 : v1), 16'(e_v[d]));
        if (ph[d] == n + 1) begin
            exp = 'x;
            if (d == 0 && exp_q0.size() > 0) exp = exp_q0.pop_front();
            if (d == 1 && exp_q1.size() > 0) exp = exp_q1.pop_front();
            check({tag, " sb_result"}, (d == 0) ? result4 : {12'h000, result1}, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            cmp_dut(0);
            cmp_dut(1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int d, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
        if (d == 0) begin
            start4 = st; a4 = a; b4 = b; sub4 = s;
        end else begin
            start1 = st; a1 = a[3:0]; b1 = b[3:0]; sub1 = s;
        end
    endtask

    // One operation; with spam set, start is re-asserted with fresh operands every busy cycle.
    task automatic run_op(input string name, input int d, input logic [15:0] a,
                          input logic [15:0] b, input logic s, input logic [15:0] er,
                          input logic ec, input logic ev, input bit spam);
        int n;
        int cyc;
        int dones;
        bit seen;
        n     = (d == 0) ? 4 : 1;
        cyc   = 0;
        dones = 0;
        seen  = 1'b0;
        @(negedge clk);
        #1;
        drive(d, 1'b1, a, b, s);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((d == 0) ? done4 : done1) begin
                dones++;
                if (!seen) begin
                    seen = 1'b1;
                    cyc  = i;
                end
            end
            if (seen && ((d == 0) ? ready4 : ready1)) break;
            #1;
            if (spam && !seen)
                drive(d, 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      1'($urandom_range(0, 1)));
            else
                drive(d, 1'b0, '0, '0, 1'b0);
        end
        check({name, " latency"}, 16'(cyc), 16'(n + 1));
        check({name, " done_count"}, 16'(dones), 16'd1);
        check({name, " result"}, (d == 0) ? result4 : {12'h000, result1}, er);
        check({name, " c"}, 16'((d == 0) ? c4 : c1), 16'(ec));
        check({name, " v"}, 16'((d == 0) ? v4 : v1), 16'(ev));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        #2;
        check("reset ready", 16'(ready4), 16'd1);
        check("reset busy", 16'(busy4), 16'd0);
        check("reset done", 16'(done4), 16'd0);
        check("reset result", result4, 16'h0000);
        check("reset c", 16'(c4), 16'd0);
        check("reset v", 16'(v4), 16'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("add_basic",  0, 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",    0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("add_carry",  0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("sub_borrow", 0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf",    0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("sub_both",   0, 16'h5555, 16'hAAAA, 1'b1, 16'hAAAB, 1'b1, 1'b1, 1'b0);
        run_op("busy_spam",  0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

        // Abort in RUN with index 2, then verify the asynchronous clear.
        @(negedge clk);
        #1;
        drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        #1;
        drive(0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort ready", 16'(ready4), 16'd1);
        check("abort busy", 16'(busy4), 16'd0);
        check("abort done", 16'(done4), 16'd0);
        check("abort result", result4, 16'h0000);
        check("abort c", 16'(c4), 16'd0);
        check("abort v", 16'(v4), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("after_abort", 0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);

        run_op("n1_add_ovf",   1, 16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b0);
        run_op("n1_sub",       1, 16'h0003, 16'h0005, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
        run_op("n1_add_carry", 1, 16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
